// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer with private HI/LO registers.
// Results are computed at launch and held pending until the latency expires.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic        req,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [31:0]   pend_hi;
    logic [31:0]   pend_lo;
    logic          pend_write;

    logic               go;
    logic               div_zero;
    logic signed [63:0] mul_a_s;
    logic signed [63:0] mul_b_s;
    logic        [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [32:0] dvd_s;
    logic signed [32:0] dvs_s;
    logic        [31:0] quot_s;
    logic        [31:0] rem_s;
    logic        [31:0] dvs_u;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;

    assign go       = start & ~req & ~busy & (mdop != 3'd0) & (mdop != 3'd7);
    assign div_zero = (rt_data == 32'd0);

    assign mul_a_s = {{32{rs_data[31]}}, rs_data};
    assign mul_b_s = {{32{rt_data[31]}}, rt_data};
    assign prod_s  = 64'(mul_a_s * mul_b_s);
    assign prod_u  = {32'd0, rs_data} * {32'd0, rt_data};

    // 33-bit signed operands make 0x80000000 / -1 representable; truncation
    // back to 32 bits then yields the architectural wraparound result.
    assign dvd_s  = {rs_data[31], rs_data};
    assign dvs_s  = div_zero ? 33'sd1 : {rt_data[31], rt_data};
    assign quot_s = 32'(dvd_s / dvs_s);
    assign rem_s  = 32'(dvd_s % dvs_s);
    assign dvs_u  = div_zero ? 32'd1 : rt_data;
    assign quot_u = rs_data / dvs_u;
    assign rem_u  = rs_data % dvs_u;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            hi         <= 32'd0;
            lo         <= 32'd0;
            count      <= '0;
            pend_hi    <= 32'd0;
            pend_lo    <= 32'd0;
            pend_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        case (mdop)
                            3'd1: begin
                                pend_hi    <= prod_s[63:32];
                                pend_lo    <= prod_s[31:0];
                                pend_write <= 1'b1;
                                count      <= CW'(MULT_CYCLES);
                                state      <= BUSY;
                                busy       <= 1'b1;
                            end
                            3'd2: begin
                                pend_hi    <= prod_u[63:32];
                                pend_lo    <= prod_u[31:0];
                                pend_write <= 1'b1;
                                count      <= CW'(MULT_CYCLES);
                                state      <= BUSY;
                                busy       <= 1'b1;
                            end
                            3'd3: begin
                                pend_hi    <= rem_s;
                                pend_lo    <= quot_s;
                                pend_write <= ~div_zero;
                                count      <= CW'(DIV_CYCLES);
                                state      <= BUSY;
                                busy       <= 1'b1;
                            end
                            3'd4: begin
                                pend_hi    <= rem_u;
                                pend_lo    <= quot_u;
                                pend_write <= ~div_zero;
                                count      <= CW'(DIV_CYCLES);
                                state      <= BUSY;
                                busy       <= 1'b1;
                            end
                            3'd5: hi <= rs_data;
                            3'd6: lo <= rs_data;
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    // A flush never cancels here: the op belongs to an older instruction.
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (pend_write) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases from the test plan plus
// randomized ops against an arithmetic reference model of HI/LO and latency.
module tb_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mdop;
    logic        req;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_ctrl #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mdop   (mdop),
        .req    (req),
        .rs_data(rs_data),
        .rt_data(rt_data),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural result of one MDU instruction given the current HI/LO.
    function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                      inout logic [31:0] h, inout logic [31:0] l);
        longint          sp, sx, sy, sq, sr;
        longint unsigned up, ux, uy;
        case (op)
            3'd1: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                h = sp[63:32];
                l = sp[31:0];
            end
            3'd2: begin
                ux = longint'(a);
                uy = longint'(b);
                up = ux * uy;
                h = up[63:32];
                l = up[31:0];
            end
            3'd3: if (b != 32'd0) begin
                sx = longint'($signed(a));
                sy = longint'($signed(b));
                sq = sx / sy;
                sr = sx % sy;
                l = sq[31:0];
                h = sr[31:0];
            end
            3'd4: if (b != 32'd0) begin
                l = a / b;
                h = a % b;
            end
            3'd5: h = a;
            3'd6: l = a;
            default: ;
        endcase
    endfunction

    // Issue one op for a cycle, then walk its expected busy window cycle by cycle.
    // mid_req / illegal_at pick a busy cycle in which to raise req or an illegal start.
    task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic rq, input int mid_req, input int illegal_at);
        logic [31:0] eh, el, oh, ol;
        int          n;
        bit          launch;
        oh = m_hi;
        ol = m_lo;
        eh = m_hi;
        el = m_lo;
        launch = !rq && op >= 3'd1 && op <= 3'd6;
        n = 0;
        if (launch) begin
            ref_model(op, a, b, eh, el);
            if (op == 3'd1 || op == 3'd2) n = MULT_N;
            if (op == 3'd3 || op == 3'd4) n = DIV_N;
        end
        start = 1'b1; mdop = op; rs_data = a; rt_data = b; req = rq;
        @(posedge clk); @(negedge clk);
        start = 1'b0; req = 1'b0; mdop = 3'd0; rs_data = $urandom; rt_data = $urandom;
        for (int i = 0; i < n; i++) begin
            check_output($sformatf("busy_c%0d_op%0d", i, op), {31'd0, busy}, 32'd1);
            check_output($sformatf("hi_hold_c%0d_op%0d", i, op), hi, oh);
            check_output($sformatf("lo_hold_c%0d_op%0d", i, op), lo, ol);
            if (i == mid_req) req = 1'b1;
            if (i == illegal_at) begin
                start = 1'b1; mdop = 3'd1; rs_data = $urandom; rt_data = $urandom;
            end
            @(posedge clk); @(negedge clk);
            start = 1'b0; req = 1'b0; mdop = 3'd0;
        end
        check_output($sformatf("busy_done_op%0d", op), {31'd0, busy}, 32'd0);
        check_output($sformatf("hi_op%0d", op), hi, eh);
        check_output($sformatf("lo_op%0d", op), lo, el);
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        logic        rrq;

        reset = 1'b1; start = 1'b0; mdop = 3'd0; req = 1'b0; rs_data = 32'd0; rt_data = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_busy", {31'd0, busy}, 32'd0);
        check_output("reset_hi", hi, 32'd0);
        check_output("reset_lo", lo, 32'd0);
        reset = 1'b0;

        apply_stimulus(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, -1, -1);
        check_output("mult_hi_const", hi, 32'hFFFFFFFF);
        check_output("mult_lo_const", lo, 32'hFFFFFFFA);

        apply_stimulus(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1, -1);
        check_output("multu_hi_const", hi, 32'hFFFFFFFE);
        check_output("multu_lo_const", lo, 32'h00000001);

        apply_stimulus(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, -1, -1);
        check_output("div_lo_const", lo, 32'hFFFFFFFD);
        check_output("div_hi_const", hi, 32'hFFFFFFFF);

        apply_stimulus(3'd4, 32'd7, 32'd0, 1'b0, -1, -1);
        check_output("divu0_hi_const", hi, 32'hFFFFFFFF);
        check_output("divu0_lo_const", lo, 32'hFFFFFFFD);

        apply_stimulus(3'd5, 32'h12345678, 32'd0, 1'b1, -1, -1);
        apply_stimulus(3'd5, 32'h12345678, 32'd0, 1'b0, -1, -1);
        check_output("mthi_const", hi, 32'h12345678);
        apply_stimulus(3'd6, 32'hCAFEF00D, 32'd0, 1'b0, -1, -1);

        apply_stimulus(3'd3, 32'd1000, 32'd7, 1'b0, 4, -1);
        apply_stimulus(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, -1, -1);
        check_output("div_ovf_lo", lo, 32'h80000000);
        check_output("div_ovf_hi", hi, 32'h00000000);

        apply_stimulus(3'd1, 32'd123456, 32'd654321, 1'b0, -1, 2);
        apply_stimulus(3'd4, 32'hDEADBEEF, 32'd13, 1'b0, -1, DIV_N - 1);

        // Reset during the third busy cycle of a mult aborts it without commit.
        start = 1'b1; mdop = 3'd1; rs_data = 32'h00010001; rt_data = 32'h00020002; req = 1'b0;
        @(posedge clk); @(negedge clk);
        start = 1'b0; mdop = 3'd0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check_output("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        check_output("midreset_busy", {31'd0, busy}, 32'd0);
        check_output("midreset_hi", hi, 32'd0);
        check_output("midreset_lo", lo, 32'd0);
        repeat (MULT_N + 2) begin
            @(posedge clk); @(negedge clk);
            check_output("noclobber_busy", {31'd0, busy}, 32'd0);
            check_output("noclobber_hi", hi, 32'd0);
            check_output("noclobber_lo", lo, 32'd0);
        end

        for (int k = 0; k < 40; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            rrq = ($urandom_range(0, 4) == 0);
            apply_stimulus(rop, ra, rb, rrq, int'($urandom_range(0, 12)), int'($urandom_range(0, 12)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
